// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational fetch-side lookup,
// EX-side training of per-entry direction counters, true-LRU allocation and a misprediction counter.
module btb_assoc #(
  parameter int XLEN     = 32,
  parameter int SETS     = 16,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     target_pc,
  output logic                valid,
  output logic                predicted_taken,
  input  logic                update,
  input  logic [XLEN-1:0]     update_pc,
  input  logic [XLEN-1:0]     update_target,
  input  logic                update_taken,
  input  logic                mispredicted,
  input  logic                invalidate,
  output logic [CNT_BITS-1:0] mispredict_count
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  if ((SETS < 2) || ((SETS & (SETS - 1)) != 0)) begin : g_bad_sets
    $error("btb_assoc: SETS must be a power of two >= 2");
  end
  if ((WAYS < 1) || (WAYS > 8) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
    $error("btb_assoc: WAYS must be a power of two in 1..8");
  end

  logic                valid_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [XLEN-1:0]     tgt_q   [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q   [SETS][WAYS];
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [IDX-1:0]      lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, lk_msb;
  logic [XLEN-1:0]     lk_target;
  logic                up_hit, free_found, do_touch;
  logic [WAY_W-1:0]    hit_way, free_way, lru_way, touch_way;
  logic [CTR_BITS-1:0] ctr_d;
  logic                unused_pc_lsbs;

  assign lk_idx = pc[IDX+1:2];
  assign lk_tag = pc[XLEN-1:IDX+2];
  assign up_idx = update_pc[IDX+1:2];
  assign up_tag = update_pc[XLEN-1:IDX+2];
  assign unused_pc_lsbs = ^{pc[1:0], update_pc[1:0]};

  // Allocation never creates duplicate tags, so OR-merging the matching ways yields the hit entry.
  always_comb begin
    lk_hit    = 1'b0;
    lk_msb    = 1'b0;
    lk_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit    = 1'b1;
        lk_msb    = lk_msb | ctr_q[lk_idx][w][CTR_BITS-1];
        lk_target = lk_target | tgt_q[lk_idx][w];
      end
    end
  end

  assign valid            = lk_hit;
  assign target_pc        = lk_target;
  assign predicted_taken  = lk_hit & lk_msb;
  assign mispredict_count = cnt_q;

  // Scanning downwards leaves the lowest-numbered invalid way in free_way.
  always_comb begin
    up_hit     = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit  = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[up_idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  assign touch_way = up_hit ? hit_way : (free_found ? free_way : lru_way);
  assign do_touch  = update && !invalidate && (up_hit || update_taken);

  always_comb begin
    ctr_d = ctr_q[up_idx][touch_way];
    if (!up_hit) begin
      ctr_d = CTR_WEAK;
    end else if (update_taken) begin
      if (ctr_d != {CTR_BITS{1'b1}}) ctr_d = ctr_d + 1'b1;
    end else begin
      if (ctr_d != '0) ctr_d = ctr_d - 1'b1;
    end
  end

  assign cnt_d = (update && mispredicted && (cnt_q != {CNT_BITS{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= CTR_WEAK;
        end
      end
    end else begin
      cnt_q <= cnt_d;
      if (invalidate) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
      end else if (do_touch) begin
        valid_q[up_idx][touch_way] <= 1'b1;
        ctr_q[up_idx][touch_way]   <= ctr_d;
      end
    end
  end

  // Tags and targets carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (do_touch && !up_hit) tag_q[up_idx][touch_way] <= up_tag;
    if (do_touch && update_taken) tgt_q[up_idx][touch_way] <= update_target;
  end

  if (WAYS > 1) begin : g_lru
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] max_age, old_age;

    always_comb begin
      lru_way = '0;
      max_age = age_q[up_idx][0];
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[up_idx][w] > max_age) begin
          max_age = age_q[up_idx][w];
          lru_way = WAY_W'(w);
        end
      end
    end

    assign old_age = age_q[up_idx][touch_way];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
        end
      end else if (invalidate) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
        end
      end else if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way) age_q[up_idx][w] <= '0;
          else if (age_q[up_idx][w] < old_age) age_q[up_idx][w] <= age_q[up_idx][w] + 1'b1;
        end
      end
    end
  end else begin : g_no_lru
    assign lru_way = '0;
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SETS=16, WAYS=2, CTR_BITS=2): lookup, training, LRU, invalidate, reset.
module tb_btb_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] target_pc;
  logic        valid;
  logic        predicted_taken;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        mispredicted;
  logic        invalidate;
  logic [15:0] mispredict_count;

  int n_asrt = 0;
  int n_fail = 0;

  btb_assoc #(.XLEN(32), .SETS(16), .WAYS(2), .CTR_BITS(2), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .target_pc(target_pc), .valid(valid),
    .predicted_taken(predicted_taken), .update(update), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .mispredicted(mispredicted), .invalidate(invalidate),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic look(input string name, input logic [31:0] p, input logic v,
                      input logic [31:0] t, input logic pt);
    pc = p;
    #1;
    chk({name, ".valid"}, {31'd0, valid}, {31'd0, v});
    chk({name, ".target"}, target_pc, t);
    chk({name, ".taken"}, {31'd0, predicted_taken}, {31'd0, pt});
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk, input logic mp);
    update_pc     = p;
    update_target = t;
    update_taken  = tk;
    mispredicted  = mp;
    update        = 1'b1;
    @(posedge clk);
    #1;
    update       = 1'b0;
    mispredicted = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; pc = '0; update = 1'b0; update_pc = '0; update_target = '0;
    update_taken = 1'b0; mispredicted = 1'b0; invalidate = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    look("reset", 32'h40, 1'b0, 32'h0, 1'b0);
    chk("reset.cnt", {16'd0, mispredict_count}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First allocation
    upd(32'h40, 32'h100, 1'b1, 1'b1);
    look("alloc", 32'h40, 1'b1, 32'h100, 1'b1);
    chk("alloc.cnt", {16'd0, mispredict_count}, 32'd1);

    // Counter 2->1->0->0, then 0->1->2
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    look("nt1", 32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    look("nt3", 32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    look("tk1", 32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    look("tk2", 32'h40, 1'b1, 32'h100, 1'b1);
    chk("train.cnt", {16'd0, mispredict_count}, 32'd1);

    // mispredicted without update is ignored
    mispredicted = 1'b1;
    @(posedge clk);
    #1;
    mispredicted = 1'b0;
    chk("noupd.cnt", {16'd0, mispredict_count}, 32'd1);

    // LRU within set 0
    upd(32'h80, 32'h280, 1'b1, 1'b0);
    look("lru.a80", 32'h80, 1'b1, 32'h280, 1'b1);
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    upd(32'h140, 32'h999, 1'b0, 1'b0);
    look("lru.nt_miss", 32'h140, 1'b0, 32'h0, 1'b0);
    upd(32'hC0, 32'h3C0, 1'b1, 1'b0);
    look("lru.h40", 32'h40, 1'b1, 32'h100, 1'b1);
    look("lru.hC0", 32'hC0, 1'b1, 32'h3C0, 1'b1);
    look("lru.m80", 32'h80, 1'b0, 32'h0, 1'b0);
    look("lru.set1", 32'h44, 1'b0, 32'h0, 1'b0);

    // Same-cycle lookup and update: read-before-write
    pc = 32'h200; update_pc = 32'h200; update_target = 32'h300;
    update_taken = 1'b1; update = 1'b1;
    #1;
    chk("rbw.before", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1;
    update = 1'b0;
    look("rbw.after", 32'h200, 1'b1, 32'h300, 1'b1);
    look("rbw.evict40", 32'h40, 1'b0, 32'h0, 1'b0);
    look("rbw.keepC0", 32'hC0, 1'b1, 32'h3C0, 1'b1);

    // Invalidate wins over update, counter still counts
    invalidate = 1'b1; update_pc = 32'h40; update_target = 32'h100;
    update_taken = 1'b1; mispredicted = 1'b1; update = 1'b1;
    @(posedge clk);
    #1;
    invalidate = 1'b0; update = 1'b0; mispredicted = 1'b0;
    look("inv.200", 32'h200, 1'b0, 32'h0, 1'b0);
    look("inv.C0", 32'hC0, 1'b0, 32'h0, 1'b0);
    look("inv.40", 32'h40, 1'b0, 32'h0, 1'b0);
    chk("inv.cnt", {16'd0, mispredict_count}, 32'd2);
    upd(32'h80, 32'h480, 1'b1, 1'b0);
    look("inv.realloc", 32'h80, 1'b1, 32'h480, 1'b1);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    look("arst", 32'h80, 1'b0, 32'h0, 1'b0);
    chk("arst.cnt", {16'd0, mispredict_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    look("post_rst", 32'h80, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer (BTB) for the pipelined RV32IM core. It is the successor to the single-entry-per-index BTB.
- Fetch side: looks up the IF-stage PC combinationally and returns the predicted target and a taken/not-taken prediction.
- Execute side: a registered update port from EX trains per-entry saturating counters, allocates entries with true-LRU replacement, and counts mispredictions.
- Also supports a global invalidate used on fence.i or context change.

Parameters:
- XLEN, 32, PC and target width.
- SETS, 16, number of sets; must be a power of two, ≥2.
- WAYS, 2, associativity; must be a power of two, 1..8.
- CTR_BITS, 2, width of the saturating direction counter; range 1..4.
- CNT_BITS, 16, width of the saturating misprediction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  XLEN  IF-stage PC to look up.
- target_pc  out  XLEN  predicted target of the hit entry; 0 on miss.
- valid  out  1  lookup hit (a valid entry has a matching tag in the indexed set).
- predicted_taken  out  1  valid & MSB of the hit entry's counter.
- update  in  1  strobe: resolved branch/jump in EX this cycle.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_target  in  XLEN  resolved target address.
- update_taken  in  1  actual outcome.
- mispredicted  in  1  EX redirect caused by this instruction; qualified by update.
- invalidate  in  1  synchronous clear of all valid bits.
- mispredict_count  out  CNT_BITS  saturating count of update&mispredicted events.

Behaviour:
- Index and tag fields:
  - IDX = log2(SETS).
  - index = pc[IDX+1:2].
  - tag = pc[XLEN-1:IDX+2].
  - pc[1:0] is ignored.
- Lookup is purely combinational, zero latency.
  - Hit = exactly one valid way with a matching tag; allocation guarantees no duplicates.
  - On miss, target_pc=0, valid=0, predicted_taken=0.
- Per-way state: valid bit, tag, target, counter. Per-set LRU state: one age of log2(WAYS) bits per way, where 0 = MRU; for WAYS=1 LRU logic is absent.
- On reset (rst low, asynchronous):
  - All valid bits = 0.
  - All counters = weakly-taken (1<<(CTR_BITS-1)).
  - Ages = way index.
  - mispredict_count = 0.
  - Outputs therefore read valid=0, target_pc=0, predicted_taken=0.
- Update, applied on the clock edge when update=1:
  - Hit in the set of update_pc:
    - Counter +1 if update_taken, else −1, saturating at 0 and 2^CTR_BITS−1.
    - If update_taken, target ← update_target.
    - The way becomes MRU.
  - Miss and update_taken:
    - Allocate the lowest-numbered invalid way; if none, the way with the maximum age (LRU).
    - Write valid=1, tag, target, counter = weakly-taken (1<<(CTR_BITS-1)).
    - The way becomes MRU.
  - Miss and not taken: no allocation, no LRU change.
  - MRU update rule: the touched way's age → 0; ways with age < the old age of the touched way increment; others are unchanged.
- Lookup does not change LRU.
- If update and lookup hit the same set in the same cycle, the lookup returns pre-update state (read-before-write); the new state is visible the next cycle.
- mispredict_count increments on update&mispredicted and saturates at all-ones; it is not cleared by invalidate.
- invalidate:
  - Clears all valid bits at the next edge and resets ages to way index.
  - Counters, tags and targets are left unchanged.
  - Takes priority over a simultaneous update: that update is dropped, but mispredict_count still increments.
- Reset asserted mid-operation overrides everything asynchronously; the first edge after release behaves as post-reset.
- Elaboration must fail (e.g. via an invalid generate) if SETS or WAYS is not a power of two.

Test Plan:
1. Reset then lookup pc=0x0000_0040 → valid=0, target_pc=0, predicted_taken=0, mispredict_count=0.
2. update pc=0x40, target=0x100, taken=1, mispredicted=1 → next cycle, lookup 0x40 gives valid=1, target_pc=0x100, predicted_taken=1, mispredict_count=1.
3. Counter saturation (CTR_BITS=2) on the entry from scenario 2:
   - Three not-taken updates: counter 2→1→0→0, predicted_taken=0 after the first; target stays 0x100.
   - Then two taken updates: predicted_taken=1 again.
4. LRU, SETS=16, WAYS=2, same set via PCs 0x40, 0x80, 0xC0 (all index 0):
   - Allocate 0x40, then 0x80, then look up and update 0x40 (hit, MRU).
   - Allocate 0xC0 → evicts 0x80. Lookups: 0x40 hit, 0xC0 hit, 0x80 miss.
5. Same-cycle lookup and update of pc=0x200 (initially miss, update taken, target 0x300) → the lookup in that cycle reads valid=0; the next cycle reads valid=1, target_pc=0x300.
6. Invalidate:
   - invalidate together with update pc=0x40 taken, mispredicted=1 → all lookups miss next cycle and mispredict_count still increments.
   - Assert rst mid-sequence → all outputs 0 immediately, without waiting for a clock edge.
